// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one registered ALU among N requesters.
// Latches the winner's operands, waits out the ALU latency and routes the result back.
module alu_share_arbiter #(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N*4-1:0] req_func,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic [W-1:0]   alu_in1,
    output logic [W-1:0]   alu_in2,
    output logic [3:0]     alu_func,
    input  logic [W-1:0]   alu_out
);

    localparam int         PW       = $clog2(N);
    localparam int         CW       = $clog2(LAT + 1);
    localparam logic [3:0] FUNC_MAX = 4'd8;

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  rsp_valid_q, rsp_valid_d;
    logic [W-1:0]  rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic [W-1:0]  in1_q, in1_d;
    logic [W-1:0]  in2_q, in2_d;
    logic [3:0]    func_q, func_d;

    logic [W-1:0]  a_arr [N];
    logic [W-1:0]  b_arr [N];
    logic [3:0]    f_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign a_arr[i] = req_a[i*W +: W];
        assign b_arr[i] = req_b[i*W +: W];
        assign f_arr[i] = req_func[i*4 +: 4];
    end

    // First set request at or above the rr pointer, wrapping modulo N.
    logic [PW-1:0] win_idx;
    logic [PW-1:0] cand;
    logic          win_vld;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int off = 0; off < N; off++) begin
            cand = PW'((int'(ptr_q) + off) % N);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = 1'b0;
        in1_d       = in1_q;
        in2_d       = in2_q;
        func_d      = func_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d[win_idx] = 1'b1;
                    in1_d          = a_arr[win_idx];
                    in2_d          = b_arr[win_idx];
                    owner_d        = win_idx;
                    ptr_d          = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
                    if (f_arr[win_idx] <= FUNC_MAX) begin
                        func_d  = f_arr[win_idx];
                        cnt_d   = CW'(LAT);
                        state_d = BUSY;
                    end else begin
                        // Illegal codes never reach the ALU; it sees ADD on held operands.
                        func_d  = 4'd0;
                        state_d = ERR;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    rsp_data_d           = alu_out;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ERR: begin
                rsp_data_d           = '0;
                rsp_valid_d[owner_q] = 1'b1;
                rsp_err_d            = 1'b1;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            in1_q       <= '0;
            in2_q       <= '0;
            func_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            func_q      <= func_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign alu_func  = func_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: requester agents, an ALU model, a
// transaction-level reference model feeding expectation queues, and a monitor.
module tb_alu_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N*4-1:0] req_func = '0;
    logic [N-1:0]   gnt, rsp_valid;
    logic [W-1:0]   rsp_data, alu_in1, alu_in2, alu_out;
    logic           rsp_err;
    logic [3:0]     alu_func;

    alu_share_arbiter #(.N(N), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .req_func(req_func), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_func(alu_func), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
        logic signed [31:0] sa;
        sa = a;
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ~a;
            4'd6: return a << b[4:0];
            4'd7: return sa >>> b[4:0];
            4'd8: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // External ALU: LAT register stages from inputs to alu_out.
    logic [W-1:0] alu_pipe [LAT];
    initial for (int k = 0; k < LAT; k++) alu_pipe[k] = '0;
    always @(posedge clk) begin
        alu_pipe[0] <= alu_ref(alu_in1, alu_in2, alu_func);
        for (int k = 1; k < LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
    end
    assign alu_out = alu_pipe[LAT-1];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-requester operation FIFOs.
    logic [31:0] op_a [N][128];
    logic [31:0] op_b [N][128];
    logic [3:0]  op_f [N][128];
    int head [N];
    int tail [N];
    initial for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end

    task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] f);
        op_a[i][tail[i]] = a;
        op_b[i][tail[i]] = b;
        op_f[i][tail[i]] = f;
        tail[i]++;
    endtask

    // Agents: pop on gnt, present next op, scribble on buses when idle.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (gnt[i] && head[i] < tail[i]) head[i]++;
            if (head[i] < tail[i]) begin
                req[i]            = 1'b1;
                req_a[i*32 +: 32] = op_a[i][head[i]];
                req_b[i*32 +: 32] = op_b[i][head[i]];
                req_func[i*4 +: 4] = op_f[i][head[i]];
            end else begin
                req[i]            = 1'b0;
                req_a[i*32 +: 32] = $urandom;
                req_b[i*32 +: 32] = $urandom;
                req_func[i*4 +: 4] = 4'($urandom);
            end
        end
    end

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] a, b, data;
        logic [3:0]  f;
        logic        err;
    } ev_t;

    ev_t gq[$];
    ev_t rq[$];
    int  cyc     = 0;
    int  m_ptr   = 0;
    int  free_at = 0;

    // Reference model: one transaction at a time, fair rotating priority.
    initial forever begin
        ev_t e;
        int  w;
        @(posedge clk);
        cyc++;
        if (!rst && cyc >= free_at && req != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && req[j]) w = j;
            end
            e.cyc = cyc;
            e.idx = w;
            e.a   = req_a[w*32 +: 32];
            e.b   = req_b[w*32 +: 32];
            e.f   = req_func[w*4 +: 4];
            gq.push_back(e);
            if (e.f <= 4'd8) begin
                e.cyc  = cyc + LAT + 1;
                e.data = alu_ref(e.a, e.b, e.f);
                e.err  = 1'b0;
            end else begin
                e.cyc  = cyc + 1;
                e.data = 32'd0;
                e.err  = 1'b1;
            end
            rq.push_back(e);
            free_at = e.cyc + 1;
            m_ptr   = (w + 1) % N;
        end
    end

    int          gseq[$];
    int          gcyc[$];
    int          rcyc[$];
    logic [31:0] last_rsp [N];
    logic        last_err [N];
    logic [31:0] last_in1 [N];

    // Monitor.
    initial forever begin
        ev_t          e;
        logic [N-1:0] exp_v;
        bit           have;
        @(negedge clk);
        if (rst) begin
            chk("gnt_in_reset", 32'(gnt), 32'd0);
            chk("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
        end else begin
            have  = 0;
            exp_v = '0;
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                e = gq.pop_front(); exp_v[e.idx] = 1'b1; have = 1;
            end
            if (have || gnt != '0) begin
                chk("gnt", 32'(gnt), 32'(exp_v));
                if (have) begin
                    chk("alu_in1_at_gnt", alu_in1, e.a);
                    chk("alu_in2_at_gnt", alu_in2, e.b);
                    chk("alu_func_at_gnt", 32'(alu_func), (e.f <= 4'd8) ? 32'(e.f) : 32'd0);
                end
            end
            for (int i = 0; i < N; i++)
                if (gnt[i]) begin gseq.push_back(i); gcyc.push_back(cyc); end
            have  = 0;
            exp_v = '0;
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                e = rq.pop_front(); exp_v[e.idx] = 1'b1; have = 1;
            end
            if (have || rsp_valid != '0) begin
                chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
                if (have) begin
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("alu_in1_held", alu_in1, e.a);
                end
            end
            for (int i = 0; i < N; i++)
                if (rsp_valid[i]) begin
                    last_rsp[i] = rsp_data;
                    last_err[i] = rsp_err;
                    last_in1[i] = alu_in1;
                    rcyc.push_back(cyc);
                end
        end
    end

    task automatic clear_logs();
        gseq.delete(); gcyc.delete(); rcyc.delete();
    endtask

    task automatic flush_model();
        gq.delete(); rq.delete(); m_ptr = 0; free_at = 0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            done = (gq.size() == 0) && (rq.size() == 0) && (req == '0);
            for (int i = 0; i < N; i++) if (head[i] != tail[i]) done = 0;
        end
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL timeout %s: pending gq=%0d rq=%0d req=%0h", name, gq.size(), rq.size(), req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        flush_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_alu_in1"}, alu_in1, 32'd0);
        chk({tag, "_alu_in2"}, alu_in2, 32'd0);
        chk({tag, "_alu_func"}, 32'(alu_func), 32'd0);
    endtask

    initial begin
        int n;
        #1 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single request.
        clear_logs();
        push_op(2, 32'd10, 32'd6, 4'd0);
        wait_done(50, "t1");
        chk("t1_rsp", last_rsp[2], 32'd16);
        chk("t1_err", 32'(last_err[2]), 32'd0);
        if (gseq.size() == 1 && rcyc.size() == 1) begin
            chk("t1_gnt_idx", 32'(gseq[0]), 32'd2);
            chk("t1_latency", 32'(rcyc[0] - gcyc[0]), 32'(LAT + 1));
        end else chk("t1_events", 32'(gseq.size() + rcyc.size()), 32'd2);

        // All four at once after reset.
        do_reset();
        clear_logs();
        push_op(0, 32'd12, 32'd2, 4'd1);
        push_op(1, 32'd23, 32'd62, 4'd2);
        push_op(2, 32'd19, 32'd81, 4'd3);
        push_op(3, 32'd51, 32'd62, 4'd4);
        wait_done(100, "t2");
        chk("t2_ngrants", 32'(gseq.size()), 32'd4);
        if (gseq.size() == 4)
            for (int i = 0; i < 4; i++) chk("t2_order", 32'(gseq[i]), 32'(i));
        chk("t2_rsp0", last_rsp[0], 32'd10);
        chk("t2_rsp1", last_rsp[1], 32'd22);
        chk("t2_rsp2", last_rsp[2], 32'd83);
        chk("t2_rsp3", last_rsp[3], 32'd13);

        // Fairness between two continuously requesting agents.
        clear_logs();
        for (int k = 0; k < 2; k++) begin
            push_op(1, 32'd9, 32'd1, 4'd6);
            push_op(3, 32'd9, 32'd1, 4'd6);
        end
        wait_done(100, "t3");
        chk("t3_ngrants", 32'(gseq.size()), 32'd4);
        if (gseq.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t3_order", 32'(gseq[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
            for (int i = 1; i < 4; i++) chk("t3_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'(LAT + 2));
        end
        chk("t3_rsp1", last_rsp[1], 32'd18);
        chk("t3_rsp3", last_rsp[3], 32'd18);

        // Illegal function code.
        clear_logs();
        push_op(0, 32'h1234, 32'h55, 4'hF);
        wait_done(50, "t4");
        chk("t4_err", 32'(last_err[0]), 32'd1);
        chk("t4_data", last_rsp[0], 32'd0);
        if (rcyc.size() == 1 && gcyc.size() == 1)
            chk("t4_latency", 32'(rcyc[0] - gcyc[0]), 32'd1);
        else chk("t4_events", 32'(gcyc.size() + rcyc.size()), 32'd2);

        // Operand stability: buses are scrambled by the idle agent while BUSY.
        clear_logs();
        push_op(1, 32'd6, 32'd1, 4'd7);
        wait_done(50, "t5");
        chk("t5_rsp", last_rsp[1], 32'd3);
        chk("t5_in1_held", last_in1[1], 32'd6);

        // Reset mid-operation, then requests on 1 and 3.
        clear_logs();
        push_op(2, 32'd5, 32'd5, 4'd0);
        n = 0;
        while (!gnt[2] && n < 50) begin @(negedge clk); n++; end
        chk("t6_gnt_seen", 32'(gnt[2]), 32'd1);
        #2 rst = 1'b1;
        flush_model();
        #1 chk_all_zero("t6_async");
        push_op(1, 32'd1, 32'd2, 4'd0);
        push_op(3, 32'd3, 32'd4, 4'd0);
        repeat (2) @(negedge clk);
        clear_logs();
        rst = 1'b0;
        wait_done(100, "t6");
        if (gseq.size() > 0) chk("t6_first_gnt", 32'(gseq[0]), 32'd1);
        else chk("t6_ngrants", 32'(gseq.size()), 32'd2);

        // Randomized batches.
        for (int bt = 0; bt < 3; bt++) begin
            for (int k = 0; k < 20; k++) begin
                logic [3:0] f;
                f = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
                push_op($urandom_range(0, N - 1), $urandom, $urandom, f);
            end
            wait_done(1000, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 32-bit ALU (funcs ADD, SUB, AND, OR, XOR, NOT, SLL, SRA, SRL) among N requesters.
- Uses round-robin arbitration. Latches the winner's operands and drives the ALU inputs.
- Waits the ALU's registered latency, then returns the result to the owning requester with a one-cycle valid pulse.
- Sits between requester blocks (sequencers, test harness) and the ALU instance.

Parameters:
- N, 4, number of requesters (2..8)
- W, 32, operand/result width
- LAT, 1, ALU latency in clock edges from stable inputs to valid out (1..15)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  N  per-requester request level
- req_a  input  N*W  operand A, slice i = [i*W +: W]
- req_b  input  N*W  operand B, same slicing
- req_func  input  N*4  function code, slice i = [i*4 +: 4]
- gnt  output  N  one-hot, one-cycle pulse: request i accepted
- rsp_valid  output  N  one-hot, one-cycle pulse: result for requester i
- rsp_data  output  W  result, valid while any rsp_valid bit is high
- rsp_err  output  1  high with rsp_valid when the func code was illegal
- alu_in1  output  W  to ALU in1
- alu_in2  output  W  to ALU in2
- alu_func  output  4  to ALU func
- alu_out  input  W  from ALU out

Behaviour:
- Reset, async, active-high: state=IDLE, rr pointer=0, counter=0, owner=0. All of gnt, rsp_valid, rsp_data, rsp_err, alu_in1, alu_in2 and alu_func are 0.
- States:
  - IDLE: waiting for a request.
  - BUSY: ALU operation in flight.
  - ERR: illegal func; response being returned.
- IDLE, with any req bit high at an edge:
  - Winner = first set bit searching from the rr pointer upward, wrapping modulo N.
  - Register gnt[winner]=1 for exactly one cycle.
  - Latch that requester's req_a, req_b and req_func into alu_in1, alu_in2 and alu_func.
  - Set owner=winner and rr pointer=(winner+1) mod N.
  - Legal func (0..8): go to BUSY with counter=LAT. Illegal func (9..15): go to ERR, and drive alu_func=0.
- BUSY:
  - alu_in1, alu_in2 and alu_func stay held constant throughout.
  - Counter decrements on each edge.
  - At the edge where counter==0: rsp_data<=alu_out, rsp_valid[owner]=1 for one cycle, rsp_err=0, state=IDLE.
- ERR: at the next edge, rsp_data<=0, rsp_valid[owner]=1, rsp_err=1 (one cycle), state=IDLE.
- Latency:
  - rsp_valid rises LAT+1 cycles after gnt rises. With LAT=1, gnt is high in cycle k and rsp_valid in cycle k+2.
  - For the ERR path, rsp_valid is high in cycle k+1.
- Throughput:
  - The next grant can occur no earlier than the edge after the response edge, i.e. the cycle after rsp_valid.
  - Back-to-back ops are spaced LAT+2 cycles apart (gnt to gnt).
- Handshake:
  - A requester holds req and its operands until it sees gnt, then deasserts req within the gnt cycle.
  - req still high in the cycle after gnt counts as a new request, subject to round-robin.
- Requests arriving while BUSY or ERR are ignored until IDLE; no queuing inside the block.
- Simultaneous requests: exactly one grant per arbitration. The rr pointer guarantees each active requester is served within N grants.
- Operand changes on the req_* buses after gnt do not affect the in-flight operation.
- rsp_data holds its last value after rsp_valid falls. gnt and rsp_valid are never high in the same cycle.
- Reset mid-operation:
  - The operation is dropped with no rsp_valid.
  - Outputs go to their reset values immediately, without waiting for clk.
  - The rr pointer returns to 0.
- Width: results are taken unmodified from alu_out. No carry or overflow reporting.

Test Plan:
1. Single request, N=4, LAT=1: req[2]=1, a=10, b=6, func=0. Expect gnt[2] in cycle k, rsp_valid[2] in cycle k+2, rsp_data=16, rsp_err=0, alu_func=0.
2. All four requesting simultaneously after reset (func 1,2,3,4 with a=12/23/19/51, b=2/62/81/62). Expect grant order 0,1,2,3 and results 10, 22, 83, 13, each rsp_valid routed to the matching requester.
3. Round-robin fairness: req[1] and req[3] held continuously with func=6 (9<<1). Expect grants to alternate 1,3,1,3, gnt-to-gnt spacing 3 cycles, and rsp_data=18 each time.
4. Illegal func=4'b1111 on requester 0: gnt[0] then, one cycle later, rsp_valid[0]=1, rsp_err=1, rsp_data=0. The ALU sees func=0.
5. Operand stability: after gnt[1] for func=7 (a=6, b=1), change req_a to 99 while BUSY. Expect rsp_data=3 and alu_in1 held at 6.
6. Reset mid-operation: assert rst in the BUSY cycle. Expect no rsp_valid, all outputs 0 asynchronously, and the first grant after release going to the lowest active requester.
